sr_latch_driver: RTL and testbench
==================================

// Module: sr_latch_driver
// PURPOSE
//   Digital initiator for the external cross-coupled NOR SR latch. Accepts set/reset/toggle/read
//   commands and drives timed S/R pulses on the latch inputs. Samples Q/Qn back through a 2-flop
//   synchroniser and reports the settled state plus a pass/fail code. Sits between the ui_in/uo_out
//   control logic and the analog latch pins.
// PARAMETERS
//   PULSE_CYC   4   cycles S or R is held high per set/reset (>=1)
//   SETTLE_CYC  3   cycles S=R=0 after pulse before sampling (>=2, covers synchroniser)
//   CNT_W       8   width of saturating error counter
// PORTS
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous active-low reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      block can accept command (high only in IDLE)
//   cmd_op     in   2      00 READ, 01 SET, 10 RESET, 11 TOGGLE
//   q_in       in   1      latch Q (asynchronous, synchronised internally)
//   qn_in      in   1      latch Qn (asynchronous, synchronised internally)
//   s_out      out  1      latch S drive (registered)
//   r_out      out  1      latch R drive (registered)
//   rsp_valid  out  1      response present, held until rsp_ready
//   rsp_ready  in   1      response consumed
//   rsp_q      out  1      synchronised Q at CHECK
//   rsp_err    out  2      00 OK, 01 MISMATCH (Q!=expected), 10 INVALID (Q==Qn)
//   busy       out  1      high in any state except IDLE
//   err_count  out  CNT_W  count of responses with rsp_err!=00, saturating
// BEHAVIOUR
//   Reset (async, rst_n low): state=IDLE, s_out=r_out=0, rsp_valid=0, rsp_q=0, rsp_err=00,
//     err_count=0, synchroniser flops=0. s_out/r_out drop immediately, including mid-pulse.
//     The latch keeps its state.
//   Invariant: s_out and r_out are never both 1.
//   States: IDLE -> PULSE -> SETTLE -> CHECK -> RESP -> IDLE.
//   IDLE: cmd_ready=1. Handshake cmd_valid&cmd_ready at edge E0 latches op and expected value:
//     SET exp=1. RESET exp=0. TOGGLE exp=~q_sync at E0 (SET if q_sync=0, else RESET).
//     READ exp=q_sync at E0, goes straight to SETTLE.
//   PULSE: drive s_out (exp=1) or r_out (exp=0) high for exactly PULSE_CYC cycles after E0.
//   SETTLE: s_out=r_out=0 for SETTLE_CYC cycles.
//   CHECK: one cycle. Sample q_sync/qn_sync.
//     err = 10 if q_sync==qn_sync, else 01 if q_sync!=exp, else 00.
//     err_count += (err!=00), saturating at all-ones.
//   RESP: rsp_valid=1, rsp_q/rsp_err stable until rsp_valid&rsp_ready, then return to IDLE.
//     cmd_ready stays 0 throughout RESP.
//   Latency from E0 to first rsp_valid cycle: PULSE_CYC+SETTLE_CYC+1 cycles for SET/RESET/TOGGLE
//     (default 8), SETTLE_CYC+1 for READ (default 4).
//   rsp_ready held high: rsp_valid is high for 1 cycle, and cmd_ready returns the next cycle.
//   cmd_valid while busy is ignored (no queueing). Command fields are don't-care outside the handshake.
//   cmd_op/q_in changes after E0 do not alter exp or the pulse.
// TESTING
//   1 SET from Q=0; model latch responds -> s_out high cycles 1-4 after E0, rsp_valid at cycle 8,
//     rsp_q=1, rsp_err=00.
//   2 TOGGLE with Q=1 -> r_out pulses 4 cycles, s_out stays 0, rsp_q=0, err=00.
//     TOGGLE again -> s_out pulses.
//   3 READ with Q=1/Qn=0 -> no S/R activity, rsp_valid at cycle 4, rsp_q=1, err=00.
//   4 Model holds Q=Qn=0 during SET -> rsp_err=10, err_count increments.
//     Stuck Q=0,Qn=1 -> rsp_err=01. Force 260 errors with CNT_W=8 -> err_count=255.
//   5 rsp_ready low for 5 cycles -> rsp_valid/rsp_q/rsp_err stable, cmd_ready=0,
//     and new cmd_valid is ignored.
//   6 rst_n low during PULSE (cycle 2) -> s_out=0 the same cycle, all outputs at reset values,
//     next command accepted normally.

Source files
------------

// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//   Drives timed S/R pulses into an external cross-coupled NOR SR latch and
//   reads Q/Qn back through a 2-flop synchroniser. Each command produces one
//   response carrying the settled Q and a pass/fail code.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_op               00 READ, 01 SET, 10 RESET, 11 TOGGLE
//   q_in, qn_in          asynchronous latch outputs
//   s_out, r_out         registered latch drives (never both high)
//   rsp_valid/rsp_ready  response handshake, response held until consumed
//   rsp_q, rsp_err       sampled Q; 00 OK, 01 MISMATCH, 10 INVALID
//   busy                 high whenever not idle
//   err_count            saturating count of non-OK responses
// -----------------------------------------------------------------------------
module sr_latch_driver #(
  parameter int unsigned PULSE_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             q_in,
  input  logic             qn_in,
  output logic             s_out,
  output logic             r_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_q,
  output logic [1:0]       rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned MAX_CYC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PULSE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_INVALID  = 2'b10;

  logic [2:0]       r_state, w_state_nxt;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic             r_exp, w_exp_nxt;
  logic             r_q_meta, r_q_sync, r_qn_meta, r_qn_sync;
  logic             r_s, w_s_nxt;
  logic             r_r, w_r_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic             r_rsp_q, w_rsp_q_nxt;
  logic [1:0]       r_rsp_err, w_rsp_err_nxt;
  logic [CNT_W-1:0] r_err_count, w_err_count_nxt;
  logic             r_cmd_ready, w_cmd_ready_nxt;
  logic             r_busy, w_busy_nxt;
  logic [1:0]       w_chk_err;

  // Next-state, timer, response and registered-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_tmr_nxt       = r_tmr;
    w_exp_nxt       = r_exp;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_q_nxt     = r_rsp_q;
    w_rsp_err_nxt   = r_rsp_err;
    w_err_count_nxt = r_err_count;
    w_chk_err       = ERR_OK;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_state_nxt = S_PULSE;
          w_tmr_nxt   = TMR_W'(PULSE_CYC - 1);
          case (cmd_op)
            OP_READ: begin
              // READ skips the pulse; expected value is the current Q
              w_exp_nxt   = r_q_sync;
              w_state_nxt = S_SETTLE;
              w_tmr_nxt   = TMR_W'(SETTLE_CYC - 1);
            end
            OP_SET:    w_exp_nxt = 1'b1;
            OP_RESET:  w_exp_nxt = 1'b0;
            OP_TOGGLE: w_exp_nxt = ~r_q_sync;
            default:   w_exp_nxt = r_exp;
          endcase
        end
      end
      S_PULSE: begin
        if (r_tmr == '0) begin
          w_state_nxt = S_SETTLE;
          w_tmr_nxt   = TMR_W'(SETTLE_CYC - 1);
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      S_SETTLE: begin
        if (r_tmr == '0) w_state_nxt = S_CHECK;
        else             w_tmr_nxt   = r_tmr - TMR_W'(1);
      end
      S_CHECK: begin
        // Q==Qn means the latch is in a forbidden/metastable condition
        if (r_q_sync == r_qn_sync)  w_chk_err = ERR_INVALID;
        else if (r_q_sync != r_exp) w_chk_err = ERR_MISMATCH;
        else                        w_chk_err = ERR_OK;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_q_nxt     = r_q_sync;
        w_rsp_err_nxt   = w_chk_err;
        if ((w_chk_err != ERR_OK) && !(&r_err_count))
          w_err_count_nxt = r_err_count + CNT_W'(1);
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Drives follow the next state so they are registered yet aligned with it
    w_s_nxt         = (w_state_nxt == S_PULSE) &&  w_exp_nxt;
    w_r_nxt         = (w_state_nxt == S_PULSE) && !w_exp_nxt;
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  // State, synchroniser and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_exp       <= 1'b0;
      r_q_meta    <= 1'b0;
      r_q_sync    <= 1'b0;
      r_qn_meta   <= 1'b0;
      r_qn_sync   <= 1'b0;
      r_s         <= 1'b0;
      r_r         <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_q     <= 1'b0;
      r_rsp_err   <= ERR_OK;
      r_err_count <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmr       <= w_tmr_nxt;
      r_exp       <= w_exp_nxt;
      r_q_meta    <= q_in;
      r_q_sync    <= r_q_meta;
      r_qn_meta   <= qn_in;
      r_qn_sync   <= r_qn_meta;
      r_s         <= w_s_nxt;
      r_r         <= w_r_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_q     <= w_rsp_q_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_err_count <= w_err_count_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign s_out     = r_s;
  assign r_out     = r_r;
  assign rsp_valid = r_rsp_valid;
  assign rsp_q     = r_rsp_q;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_sr_latch_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_driver
//   Directed bench for sr_latch_driver with a behavioural NOR-latch model that
//   can be forced into invalid (Q=Qn=0) or stuck (Q=0,Qn=1) conditions.
// -----------------------------------------------------------------------------
module tb_sr_latch_driver;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       q_in;
  logic       qn_in;
  logic       s_out;
  logic       r_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_q;
  logic [1:0] rsp_err;
  logic       busy;
  logic [7:0] err_count;

  int n_vec;
  int n_bad;

  // Latch model: 0 normal, 1 forced Q=Qn=0, 2 stuck Q=0/Qn=1
  logic m_q;
  int   mode;

  always @(posedge s_out) m_q = 1'b1;
  always @(posedge r_out) m_q = 1'b0;

  assign q_in  = (mode == 0) ? m_q  : 1'b0;
  assign qn_in = (mode == 0) ? ~m_q : ((mode == 1) ? 1'b0 : 1'b1);

  sr_latch_driver #(
    .PULSE_CYC (4),
    .SETTLE_CYC(3),
    .CNT_W     (8)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .q_in     (q_in),
    .qn_in    (qn_in),
    .s_out    (s_out),
    .r_out    (r_out),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_q    (rsp_q),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the handshake edge E0
  task automatic send(input logic [1:0] op);
    int w;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("send_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
  endtask

  // Index k = number of posedges after E0 at the sampling negedge
  task automatic do_cmd(input string tag, input logic [1:0] op,
                        input int exp_s, input int exp_r, input int exp_lat,
                        input logic exp_q, input logic [1:0] exp_err);
    int ns, nr, nv, lat, both, k;
    logic gq;
    logic [1:0] ge;
    bit done;
    ns = 0; nr = 0; nv = 0; lat = -1; both = 0; k = 0; done = 0;
    gq = 1'bx; ge = 2'bxx;
    send(op);
    while (!done && k < 40) begin
      @(negedge clk);
      if (s_out) ns++;
      if (r_out) nr++;
      if (s_out && r_out) both++;
      if (rsp_valid) begin
        nv++;
        if (lat < 0) begin
          lat = k;
          gq  = rsp_q;
          ge  = rsp_err;
        end
      end
      if (k > 0 && cmd_ready) done = 1;
      k++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_s_cycles"}, 32'(ns), 32'(exp_s));
    check({tag, "_r_cycles"}, 32'(nr), 32'(exp_r));
    check({tag, "_sr_both"}, 32'(both), 32'd0);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_valid_cycles"}, 32'(nv), 32'd1);
    check({tag, "_rsp_q"}, 32'(gq), 32'(exp_q));
    check({tag, "_rsp_err"}, 32'(ge), 32'(exp_err));
  endtask

  initial begin
    int w;
    n_vec     = 0;
    n_bad     = 0;
    m_q       = 1'b0;
    mode      = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_READ;
    rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_s_out", 32'(s_out), 32'd0);
    check("rst_r_out", 32'(r_out), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // SET from Q=0, then TOGGLE twice, then READ
    do_cmd("set", OP_SET, 4, 0, 8, 1'b1, 2'b00);
    do_cmd("tog1", OP_TOGGLE, 0, 4, 8, 1'b0, 2'b00);
    do_cmd("tog2", OP_TOGGLE, 4, 0, 8, 1'b1, 2'b00);
    do_cmd("read", OP_READ, 0, 0, 4, 1'b1, 2'b00);

    // Response back-pressure: held response, ignored command
    rsp_ready = 1'b0;
    send(OP_READ);
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("bp_valid_seen", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_RESET;
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_q", 32'(rsp_q), 32'd1);
      check("bp_rsp_err", 32'(rsp_err), 32'd0);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_r_out", 32'(r_out), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("bp_no_cmd_busy", 32'(busy), 32'd0);
    check("bp_latch_kept", 32'(m_q), 32'd1);

    // Error classification
    mode = 1;
    do_cmd("inv_set", OP_SET, 4, 0, 8, 1'b0, 2'b10);
    check("errcnt_1", 32'(err_count), 32'd1);
    mode = 2;
    do_cmd("mis_set", OP_SET, 4, 0, 8, 1'b0, 2'b01);
    check("errcnt_2", 32'(err_count), 32'd2);

    // Saturation: 260 errors total
    mode = 1;
    repeat (252) do_cmd("inv_rd", OP_READ, 0, 0, 4, 1'b0, 2'b10);
    check("errcnt_254", 32'(err_count), 32'd254);
    repeat (6) do_cmd("inv_rd", OP_READ, 0, 0, 4, 1'b0, 2'b10);
    check("errcnt_sat", 32'(err_count), 32'd255);

    // Reset during the pulse
    mode = 0;
    send(OP_SET);
    @(negedge clk);
    check("mid_s_high", 32'(s_out), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_s_out", 32'(s_out), 32'd0);
    check("mid_rst_r_out", 32'(r_out), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_err", 32'(rsp_err), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_errcnt", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_cmd("post_rst", OP_RESET, 0, 4, 8, 1'b0, 2'b00);
    check("post_rst_errcnt", 32'(err_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
